kw_arb_rr_mux: RTL

KW_ARB_RR_MUX -- requirements
Module: KW_arb_rr_mux

---
 rtl/kw_arb_pkg.sv | 23 ++
 rtl/kw_arb_rr_mux_pick.sv | 31 +++
 rtl/kw_arb_rr_mux.sv | 124 ++++++++++++
 3 files changed

// File: rtl/kw_arb_pkg.sv
// Shared types for the round-robin packet arbiter.
// Holds the FSM state enum and a onehot-to-index helper.
package kw_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Widest onehot vector the index helper accepts.
  localparam int MAX_N = 32;

  // OR of the set-bit positions; exact for onehot, 0 for all-zero.
  function automatic int oh2idx(input logic [MAX_N-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/kw_arb_rr_mux_pick.sv
// Combinational round-robin pick (N <= 32).
// Ports: ptr/valid in; onehot gnt and its index idx out.
module kw_arb_rr_mux_pick
  import kw_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [SW-1:0] ptr,
  input  logic [N-1:0]  valid,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] idx
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] hi;
  logic [N-1:0] pool;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      hi_mask[i] = (i >= int'(ptr));
    end
  end

  // Prefer channels at/after ptr; else wrap to the low ones.
  assign hi   = valid & hi_mask;
  assign pool = (|hi) ? hi : valid;
  assign gnt  = pool & (~pool + N'(1));
  assign idx  = SW'(oh2idx(MAX_N'(gnt)));

endmodule

// File: rtl/kw_arb_rr_mux.sv
// Round-robin N:1 packet mux with a registered output stage.
// Ports: clock/reset, in_* per client, out_* stream, busy=lock.
module kw_arb_rr_mux
  import kw_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 32,
  parameter int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N-1:0]        in_valid,
  input  logic [N-1:0][W-1:0] in_data,
  input  logic [N-1:0]        in_last,
  output logic [N-1:0]        in_ready,
  output logic                out_valid,
  output logic [W-1:0]        out_data,
  output logic                out_last,
  output logic [SW-1:0]       out_sel,
  input  logic                out_ready,
  output logic                busy
);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] lock_q, lock_d;
  logic [N-1:0]  pick_gnt;
  logic [SW-1:0] pick_idx;
  logic [N-1:0]  gnt;
  logic [SW-1:0] src;
  logic          can_load;
  logic          take;
  logic          take_last;

  kw_arb_rr_mux_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .ptr   (ptr_q),
    .valid (in_valid),
    .gnt   (pick_gnt),
    .idx   (pick_idx)
  );

  assign can_load = !out_valid || out_ready;

  always_comb begin
    gnt = '0;
    src = pick_idx;
    unique case (state_q)
      IDLE: begin
        gnt = pick_gnt;
        src = pick_idx;
      end
      LOCK: begin
        gnt = N'(1) << lock_q;
        src = lock_q;
      end
      default: ;
    endcase
  end

  assign in_ready  = can_load ? gnt : '0;
  assign take      = |(in_valid & in_ready);
  assign take_last = |(in_valid & in_ready & in_last);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    if (take) begin
      if (take_last) begin
        state_d = IDLE;
        ptr_d   = (int'(src) == N - 1) ? '0 : src + SW'(1);
      end else begin
        state_d = LOCK;
        lock_d  = src;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      lock_q    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      if (can_load) begin
        out_valid <= take;
        if (take) begin
          out_last <= take_last;
          out_sel  <= src;
        end
      end
    end
  end

  // Payload needs no reset; out_valid qualifies it.
  always_ff @(posedge clock) begin
    if (can_load && take) out_data <= in_data[src];
  end

  assign busy = (state_q == LOCK);

  a_gnt_oh : assert property (
    @(posedge clock) disable iff (reset) $onehot0(gnt));

  a_rdy_oh : assert property (
    @(posedge clock) disable iff (reset) $onehot0(in_ready));

  for (genvar i = 0; i < N; i++) begin : g_hold
    a_hold : assert property (
      @(posedge clock) disable iff (reset)
      in_valid[i] && !in_ready[i] |=>
        in_valid[i] && $stable(in_data[i]));
  end

endmodule
